// File: rtl/device_arbiter_rr.sv
// Round-robin / fixed-priority arbiter that multiplexes N bus controllers onto
// one memory-mapped device bank, with per-controller burst lock and an
// in-order read-ack routing FIFO.
//
// Ports:
//   i_clk, i_reset_n                clock, asynchronous active-low reset
//   i_request/i_write/i_lock        per-controller request, write/read, burst hold
//   i_bank/i_address/i_data         per-controller bank select, address, write data
//   o_busy                          per-controller: eligible but not accepted
//   o_ack/o_data                    per-controller read-ack and read-data broadcast
//   o_device_*                      granted transfer presented to the device
//   i_device_busy/ack/data          device stall, read-data valid, read data
//   o_pending                       number of outstanding reads
//   o_ack_overflow                  sticky: device ack seen with nothing outstanding
module device_arbiter_rr #(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter int unsigned ADDRESS_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter logic [3:0]  DEVICE_BANK     = 4'd0,
  parameter int unsigned ACK_FIFO_LENGTH = 4,
  parameter bit          ROUND_ROBIN     = 1'b1
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset_n,
  input  logic [NUM_CONTROLLERS-1:0]               i_request,
  input  logic [NUM_CONTROLLERS-1:0]               i_write,
  input  logic [NUM_CONTROLLERS-1:0]               i_lock,
  input  logic [4*NUM_CONTROLLERS-1:0]             i_bank,
  input  logic [ADDRESS_WIDTH*NUM_CONTROLLERS-1:0] i_address,
  input  logic [DATA_WIDTH*NUM_CONTROLLERS-1:0]    i_data,
  output logic [NUM_CONTROLLERS-1:0]               o_busy,
  output logic [NUM_CONTROLLERS-1:0]               o_ack,
  output logic [DATA_WIDTH*NUM_CONTROLLERS-1:0]    o_data,
  output logic                                     o_device_request,
  output logic                                     o_device_write,
  output logic [ADDRESS_WIDTH-1:0]                 o_device_address,
  output logic [DATA_WIDTH-1:0]                    o_device_data,
  input  logic                                     i_device_busy,
  input  logic                                     i_device_ack,
  input  logic [DATA_WIDTH-1:0]                    i_device_data,
  output logic [$clog2(ACK_FIFO_LENGTH+1)-1:0]     o_pending,
  output logic                                     o_ack_overflow
);

  localparam int unsigned N          = NUM_CONTROLLERS;
  localparam int unsigned IDX_W      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PTR_W      = $clog2(ACK_FIFO_LENGTH);
  localparam int unsigned CNT_W      = $clog2(ACK_FIFO_LENGTH + 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(ACK_FIFO_LENGTH);

  logic [N-1:0]             elig;
  logic                     any_elig;
  logic                     owner_elig;
  logic [IDX_W-1:0]         grant;
  logic                     found;
  logic [N-1:0]             grant_oh;
  logic                     grant_write;
  logic                     grant_lock;
  logic [ADDRESS_WIDTH-1:0] grant_address;
  logic [DATA_WIDTH-1:0]    grant_data;
  logic                     fifo_full;
  logic                     read_blocked;
  logic                     stall;
  logic                     accept;
  logic                     push;
  logic                     pop;

  logic [IDX_W-1:0]         r_last;
  logic                     lock_valid;
  logic [IDX_W-1:0]         owner;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  logic [N-1:0]             fifo_mem [ACK_FIFO_LENGTH];

  // Eligibility: requesting and addressing this bank.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      elig[i] = i_request[i] && (i_bank[4*i +: 4] == DEVICE_BANK);
    end
  end

  assign any_elig = |elig;

  // Whether the current lock owner is still eligible.
  always_comb begin
    owner_elig = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IDX_W'(i) == owner && elig[i]) owner_elig = 1'b1;
    end
  end

  // Grant selection. Round-robin searches indices above r_last first, then
  // wraps to the bottom; the second pass alone is the fixed-priority search.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (lock_valid && owner_elig) begin
      grant = owner;
      found = 1'b1;
    end else begin
      if (ROUND_ROBIN) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (!found && elig[i] && (i > 32'(r_last))) begin
            grant = IDX_W'(i);
            found = 1'b1;
          end
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && elig[i]) begin
          grant = IDX_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  // Mux the granted controller's transfer; all zero when nothing is eligible.
  always_comb begin
    grant_oh      = '0;
    grant_write   = 1'b0;
    grant_lock    = 1'b0;
    grant_address = '0;
    grant_data    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (any_elig && IDX_W'(i) == grant) begin
        grant_oh[i]   = 1'b1;
        grant_write   = i_write[i];
        grant_lock    = i_lock[i];
        grant_address = i_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        grant_data    = i_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A same-cycle device ack frees a slot, so a full FIFO can still take a read.
  assign fifo_full    = (count == DEPTH) && !i_device_ack;
  assign read_blocked = any_elig && !grant_write && fifo_full;
  assign stall        = i_device_busy || read_blocked;
  assign accept       = any_elig && !stall;
  assign push         = accept && !grant_write;
  assign pop          = i_device_ack && (count != '0);

  assign o_busy           = elig & ~(accept ? grant_oh : '0);
  assign o_device_request = any_elig && !read_blocked;
  assign o_device_write   = grant_write;
  assign o_device_address = grant_address;
  assign o_device_data    = grant_data;
  assign o_ack            = {N{pop}} & fifo_mem[rd_ptr];
  assign o_data           = {N{i_device_data}};
  assign o_pending        = count;

  // Arbitration, lock and FIFO bookkeeping state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last         <= IDX_W'(N - 1);
      lock_valid     <= 1'b0;
      owner          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      o_ack_overflow <= 1'b0;
    end else begin
      if (accept) begin
        r_last     <= grant;
        lock_valid <= grant_lock;
        if (grant_lock) owner <= grant;
      end else if (lock_valid && !owner_elig) begin
        // Owner dropped its request: release so others are not starved.
        lock_valid <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);

      if (i_device_ack && count == '0) o_ack_overflow <= 1'b1;
    end
  end

  // Ack routing storage: one-hot issuer of each accepted read.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= grant_oh;
  end

endmodule

// File: tb/tb_device_arbiter_rr.sv
module tb_device_arbiter_rr;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req, wr, lock;
  logic [4*N-1:0]  bank;
  logic [AW*N-1:0] addr;
  logic [DW*N-1:0] wdata;
  logic            dbusy, dack;
  logic [DW-1:0]   ddata;

  logic [N-1:0]    rr_busy, rr_ack, fp_busy, fp_ack;
  logic [DW*N-1:0] rr_odata, fp_odata;
  logic            rr_dreq, rr_dwr, fp_dreq, fp_dwr;
  logic [AW-1:0]   rr_daddr, fp_daddr;
  logic [DW-1:0]   rr_ddata, fp_ddata;
  logic [2:0]      rr_pend, fp_pend;
  logic            rr_ovf, fp_ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         rst;
    logic [2:0] req, wr, lock;
    logic [11:0] bank;
    logic       dbusy, dack;
    int         eg;
    logic [2:0] ebusy;
    logic       edreq;
    logic [2:0] epend;
    logic       eovf;
  } vec_t;

  vec_t         tbl[$];
  logic [N-1:0] sb[$];

  device_arbiter_rr #(.NUM_CONTROLLERS(N), .ROUND_ROBIN(1'b1)) dut_rr (
    .i_clk(clk), .i_reset_n(rst_n), .i_request(req), .i_write(wr), .i_lock(lock),
    .i_bank(bank), .i_address(addr), .i_data(wdata), .o_busy(rr_busy), .o_ack(rr_ack),
    .o_data(rr_odata), .o_device_request(rr_dreq), .o_device_write(rr_dwr),
    .o_device_address(rr_daddr), .o_device_data(rr_ddata), .i_device_busy(dbusy),
    .i_device_ack(dack), .i_device_data(ddata), .o_pending(rr_pend), .o_ack_overflow(rr_ovf));

  device_arbiter_rr #(.NUM_CONTROLLERS(N), .ROUND_ROBIN(1'b0)) dut_fp (
    .i_clk(clk), .i_reset_n(rst_n), .i_request(req), .i_write(wr), .i_lock(lock),
    .i_bank(bank), .i_address(addr), .i_data(wdata), .o_busy(fp_busy), .o_ack(fp_ack),
    .o_data(fp_odata), .o_device_request(fp_dreq), .o_device_write(fp_dwr),
    .o_device_address(fp_daddr), .o_device_data(fp_ddata), .i_device_busy(dbusy),
    .i_device_ack(dack), .i_device_data(ddata), .o_pending(fp_pend), .o_ack_overflow(fp_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, logic [2:0] rq, logic [2:0] w, logic [2:0] lk,
                              logic [11:0] bk, logic db, logic da, int eg,
                              logic [2:0] eb, logic edr, logic [2:0] ep, logic eo);
    vec_t v;
    v.rst = rst; v.req = rq; v.wr = w; v.lock = lk; v.bank = bk; v.dbusy = db;
    v.dack = da; v.eg = eg; v.ebusy = eb; v.edreq = edr; v.epend = ep; v.eovf = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; wr = '0; lock = '0; bank = '0; dbusy = 1'b0; dack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Drive one table row, predict ack routing via the scoreboard, compare.
  task automatic apply(input vec_t v, input int idx);
    logic [2:0]    el, acc, eack, wv;
    logic          ewr;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    @(negedge clk);
    req = v.req; wr = v.wr; lock = v.lock; bank = v.bank;
    dbusy = v.dbusy; dack = v.dack; ddata = 32'hA500_0000 + 32'(idx);
    #2;
    el = v.req & {bank[11:8] == 4'h0, bank[7:4] == 4'h0, bank[3:0] == 4'h0};
    eack = '0;
    if (v.dack && sb.size() > 0) eack = sb.pop_front();
    acc = el & ~v.ebusy;
    if (acc != '0 && (acc & ~v.wr) != '0) sb.push_back(acc);
    wv = v.wr;
    ewr = 1'b0; eaddr = '0; edata = '0;
    if (v.eg >= 0) begin
      ewr   = wv[v.eg];
      eaddr = 26'h100 + AW'(v.eg);
      edata = 32'hD000_0000 + 32'(v.eg);
    end
    chk($sformatf("r%0d busy", idx),    128'(rr_busy),  128'(v.ebusy));
    chk($sformatf("r%0d dreq", idx),    128'(rr_dreq),  128'(v.edreq));
    chk($sformatf("r%0d pending", idx), 128'(rr_pend),  128'(v.epend));
    chk($sformatf("r%0d overflow", idx),128'(rr_ovf),   128'(v.eovf));
    chk($sformatf("r%0d ack", idx),     128'(rr_ack),   128'(eack));
    chk($sformatf("r%0d dwrite", idx),  128'(rr_dwr),   128'(ewr));
    chk($sformatf("r%0d daddr", idx),   128'(rr_daddr), 128'(eaddr));
    chk($sformatf("r%0d ddata", idx),   128'(rr_ddata), 128'(edata));
    chk($sformatf("r%0d odata", idx),   128'(rr_odata), 128'({3{ddata}}));
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; wr = '0; lock = '0; bank = '0; dbusy = 1'b0; dack = 1'b0; ddata = '0;
    addr  = {26'h102, 26'h101, 26'h100};
    wdata = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    //         rst  req     wr      lock    bank     db    da    g   busy    dreq  pend ovf
    // Round-robin reads, FIFO fills, full+ack accepts, drain, underflow.
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0,  0, 3'b110, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0,  1, 3'b101, 1'b1, 3'd1, 1'b0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0,  2, 3'b011, 1'b1, 3'd2, 1'b0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0,  0, 3'b110, 1'b1, 3'd3, 1'b0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0,  1, 3'b111, 1'b0, 3'd4, 1'b0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1,  1, 3'b101, 1'b1, 3'd4, 1'b0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1,  2, 3'b011, 1'b1, 3'd4, 1'b0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1,  0, 3'b110, 1'b1, 3'd4, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1, -1, 3'b000, 1'b0, 3'd4, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1, -1, 3'b000, 1'b0, 3'd3, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1, -1, 3'b000, 1'b0, 3'd2, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1, -1, 3'b000, 1'b0, 3'd1, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1, -1, 3'b000, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, -1, 3'b000, 1'b0, 3'd0, 1'b1));
    // Burst lock: hold, release by i_lock, release by dropped request, survive a stall.
    tbl.push_back(mk(1, 3'b011, 3'b011, 3'b001, 12'h000, 1'b0, 1'b0,  0, 3'b010, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b001, 12'h000, 1'b0, 1'b0,  0, 3'b010, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b000, 12'h000, 1'b0, 1'b0,  0, 3'b010, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b000, 12'h000, 1'b0, 1'b0,  1, 3'b001, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b001, 12'h000, 1'b0, 1'b0,  0, 3'b010, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b010, 3'b011, 3'b001, 12'h000, 1'b0, 1'b0,  1, 3'b000, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b011, 12'h000, 1'b0, 1'b0,  0, 3'b010, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b011, 12'h000, 1'b1, 1'b0,  0, 3'b011, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b000, 12'h000, 1'b0, 1'b0,  0, 3'b010, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b011, 3'b000, 12'h000, 1'b0, 1'b0,  1, 3'b001, 1'b1, 3'd0, 1'b0));
    // Foreign bank is invisible; a mixed-bank read still routes its ack.
    tbl.push_back(mk(1, 3'b001, 3'b000, 3'b000, 12'h003, 1'b0, 1'b0, -1, 3'b000, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 3'b000, 12'h003, 1'b0, 1'b0, -1, 3'b000, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 3'b000, 12'h003, 1'b0, 1'b0,  1, 3'b000, 1'b1, 3'd0, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, -1, 3'b000, 1'b0, 3'd1, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b1, -1, 3'b000, 1'b0, 3'd1, 1'b0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, -1, 3'b000, 1'b0, 3'd0, 1'b0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i], i);
    end

    // Fixed priority: controller 1 always wins; round-robin alternates 1,2.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = 3'b110; wr = 3'b110; lock = '0; bank = '0;
      #2;
      chk($sformatf("fp busy k%0d", k),  128'(fp_busy),  128'(3'b100));
      chk($sformatf("fp daddr k%0d", k), 128'(fp_daddr), 128'(26'h101));
      chk($sformatf("rr alt busy k%0d", k), 128'(rr_busy),
          (k % 2 == 0) ? 128'(3'b100) : 128'(3'b010));
    end

    // Underflow flag, then async reset mid-cycle clears flag, count and lock.
    do_reset();
    @(negedge clk);
    req = '0; dack = 1'b1;
    #2;
    chk("uf ack", 128'(rr_ack), 128'(3'b000));
    chk("uf ovf pre", 128'(rr_ovf), 128'(1'b0));
    @(negedge clk);
    dack = 1'b0;
    #2;
    chk("uf ovf set", 128'(rr_ovf), 128'(1'b1));
    @(negedge clk);
    req = 3'b010; wr = 3'b000; lock = 3'b010;
    #2;
    chk("lk accept busy", 128'(rr_busy), 128'(3'b000));
    @(negedge clk);
    dbusy = 1'b1;
    #2;
    chk("lk stall busy", 128'(rr_busy), 128'(3'b010));
    chk("lk pending", 128'(rr_pend), 128'(3'd1));
    chk("uf ovf sticky", 128'(rr_ovf), 128'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    chk("async ovf", 128'(rr_ovf), 128'(1'b0));
    chk("async pending", 128'(rr_pend), 128'(3'd0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    req = 3'b011; wr = 3'b011; lock = '0; dbusy = 1'b0;
    #2;
    chk("post rst lock gone", 128'(rr_busy), 128'(3'b010));
    @(negedge clk);
    req = '0; dack = 1'b1;
    #2;
    chk("post rst ack", 128'(rr_ack), 128'(3'b000));
    @(negedge clk);
    dack = 1'b0;
    #2;
    chk("post rst ovf", 128'(rr_ovf), 128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/device_arbiter_rr.md
Name: device_arbiter_rr

Overview:
Parametrised next-generation arbiter that multiplexes N bus controllers onto one memory-mapped device bank. Compared with the fixed-priority version, it adds:
- a selectable round-robin policy;
- a per-controller burst lock;
- a count-based ack FIFO that uses its full depth;
- an outstanding-read counter;
- an ack-underflow error flag.

It sits between the controller fabric and a single device, for example SDRAM or flash, and routes read acks back to the issuing controller in order.

Parameters:
NUM_CONTROLLERS, 2, number of requesting controllers (>=1)
ADDRESS_WIDTH, 26, device address width
DATA_WIDTH, 32, data bus width
DEVICE_BANK, 4'd0, bank ID this arbiter decodes
ACK_FIFO_LENGTH, 4, maximum outstanding reads; must be a power of two, >=2
ROUND_ROBIN, 1, 1 = rotating priority, 0 = fixed priority (lowest index wins)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_request  in  N  per-controller request
i_write  in  N  per-controller write (1) / read (0)
i_lock  in  N  hold the grant after this transfer (burst)
i_bank  in  4*N  per-controller bank select
i_address  in  ADDRESS_WIDTH*N  per-controller address
i_data  in  DATA_WIDTH*N  per-controller write data
o_busy  out  N  request not accepted this cycle
o_ack  out  N  read data valid for that controller
o_data  out  DATA_WIDTH*N  i_device_data broadcast to all slices
o_device_request  out  1  request to device
o_device_write  out  1  write strobe
o_device_address  out  ADDRESS_WIDTH  granted address
o_device_data  out  DATA_WIDTH  granted write data
i_device_busy  in  1  device stall
i_device_ack  in  1  device read data valid
i_device_data  in  DATA_WIDTH  device read data
o_pending  out  $clog2(ACK_FIFO_LENGTH+1)  outstanding reads
o_ack_overflow  out  1  sticky: ack received with no read outstanding

Behaviour:
- Eligibility: elig[i] = i_request[i] && i_bank[i] == DEVICE_BANK.
- Grant selection (combinational, same cycle):
  - If the lock is valid and elig[owner] is set: grant = owner, exclusively.
  - Otherwise, with ROUND_ROBIN=0: lowest eligible index wins.
  - Otherwise, with ROUND_ROBIN=1: first eligible index searching upward from (r_last+1) mod N, wrapping around.
- FIFO full: fifo_full = (count == ACK_FIFO_LENGTH) && !i_device_ack. A pop in the same cycle frees a slot.
- Request gating: stall = i_device_busy || (!i_write[g] && fifo_full).
- o_device_request = any elig && !(grant is read && fifo_full). The device never sees an untrackable read.
- Device-side muxing: o_device_write/address/data come from the granted controller; they are 0 when nothing is eligible.
- Acceptance: accept[i] = (i == g) && elig[i] && !stall. o_busy[i] = elig[i] && !accept[i]. Non-eligible controllers see busy = 0.
- On accept (registered):
  - r_last <= g.
  - If i_lock[g]: lock_valid <= 1, owner <= g. Otherwise lock_valid <= 0.
- Lock release:
  - Lock is also cleared on any cycle where elig[owner] = 0, so a dropped request cannot starve others.
  - Lock is not cleared by a stall.
- Ack FIFO:
  - Push the one-hot grant on an accepted read.
  - Pop on i_device_ack when count > 0.
  - Push and pop in the same cycle: count is unchanged, both pointers advance.
  - Pointers wrap modulo ACK_FIFO_LENGTH.
  - count ranges 0..ACK_FIFO_LENGTH; o_pending = count.
- o_ack = {N{i_device_ack && count>0}} & fifo[rdptr]. The ack is combinational in the same cycle as i_device_ack.
- Ack underflow: i_device_ack with count == 0 gives o_ack = 0, leaves pointers unchanged, and sets o_ack_overflow <= 1. The flag is cleared only by reset.
- o_data: every slice equals i_device_data, always.
- Writes produce no ack and no FIFO entry.
- Reset (async, i_reset_n low):
  - rdptr, wrptr and count = 0.
  - r_last = N-1, so controller 0 is first after reset.
  - lock_valid = 0, o_ack_overflow = 0.
  - Registered state only. Combinational outputs follow the inputs and the reset state.
  - Reset mid-operation discards all outstanding read entries. Acks arriving after reset release set o_ack_overflow.
- N=1: grant is always index 0; the round-robin logic is degenerate but legal.

Test Plan:
1. RR=1, N=3, all three request reads every cycle, device idle → grants in order 0,1,2,0; each acked controller is the one whose read was accepted 4 reads earlier in FIFO order. Busy is asserted on the two losers each cycle.
2. RR=0, N=3, controllers 1 and 2 request continuously → controller 1 is always granted; o_busy = 3'b100 every cycle.
3. LENGTH=4, four accepted reads with no ack → o_pending = 4, fifth read busy, o_device_request = 0. Fifth read plus i_device_ack in the same cycle → accepted, o_pending stays 4, o_ack goes to the first requester.
4. Controller 0 writes with i_lock=1 for 3 beats while controller 1 requests → controller 1 busy for all 3 beats. Controller 0 drops i_lock on beat 3 → controller 1 granted the next cycle. Repeat with controller 0 deasserting i_request mid-burst → lock releases immediately.
5. i_device_ack with o_pending = 0 → o_ack = 0, o_ack_overflow = 1 and it stays set. Async reset asserted mid-cycle → flag, o_pending and lock cleared without waiting for a clock edge.
6. Request to bank 4'd3 with DEVICE_BANK = 0 → o_busy = 0, o_device_request = 0, nothing pushed into the FIFO.
